// File: rtl/act_pwl_pipe.sv
// Table-programmable piecewise-linear activation: y = sat(((x - bp[i]) >>> shift[i]) + bias[i]).
// Three registered stages (select, delta, output) that advance together under a single enable.
module act_pwl_pipe #(
    parameter int DATA_W  = 16,
    parameter int SEG_N   = 16,
    parameter int SHIFT_W = 4,
    localparam int SEG_W  = $clog2(SEG_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_y,
    output logic               out_sat,
    input  logic               cfg_we,
    input  logic [SEG_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]  cfg_bp,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [DATA_W-1:0]  cfg_bias,
    input  logic               cfg_zero
);

    localparam logic [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Segment table (flops: it must reset to a known all-zero-output state)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  bp_reg    [SEG_N];
    logic [SHIFT_W-1:0] shift_reg [SEG_N];
    logic [DATA_W-1:0]  bias_reg  [SEG_N];
    logic               zero_reg  [SEG_N];

    generate
        for (genvar gi = 0; gi < SEG_N; gi++) begin : g_table
            always_ff @(posedge clk) begin
                if (rst) begin
                    bp_reg[gi]    <= '0;
                    shift_reg[gi] <= '0;
                    bias_reg[gi]  <= '0;
                    zero_reg[gi]  <= 1'b1;
                end else if (cfg_we && cfg_addr == SEG_W'(gi)) begin
                    bp_reg[gi]    <= cfg_bp;
                    shift_reg[gi] <= cfg_shift;
                    bias_reg[gi]  <= cfg_bias;
                    zero_reg[gi]  <= cfg_zero;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline enable: every stage moves when the output slot frees up
    // ------------------------------------------------------------------
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // S1: segment select. Entry 0 is the fallback, so it has no comparator.
    // ------------------------------------------------------------------
    logic [SEG_N-1:1] ge;
    logic [SEG_W-1:0] sel;

    generate
        for (genvar gi = 1; gi < SEG_N; gi++) begin : g_cmp
            assign ge[gi] = $signed(in_x) >= $signed(bp_reg[gi]);
        end
    endgenerate

    // Later indices override earlier ones, giving the largest matching k
    // even when the table is not monotonic.
    always_comb begin
        sel = '0;
        for (int k = 1; k < SEG_N; k++) begin
            if (ge[k]) begin
                sel = SEG_W'(k);
            end
        end
    end

    logic               v1_reg;
    logic [DATA_W-1:0]  x1_reg;
    logic [DATA_W-1:0]  bp1_reg;
    logic [SHIFT_W-1:0] sh1_reg;
    logic [DATA_W-1:0]  bias1_reg;
    logic               z1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            x1_reg    <= '0;
            bp1_reg   <= '0;
            sh1_reg   <= '0;
            bias1_reg <= '0;
            z1_reg    <= 1'b0;
        end else if (en) begin
            v1_reg    <= in_valid;
            x1_reg    <= in_x;
            bp1_reg   <= bp_reg[sel];
            sh1_reg   <= shift_reg[sel];
            bias1_reg <= bias_reg[sel];
            z1_reg    <= zero_reg[sel];
        end
    end

    // ------------------------------------------------------------------
    // S2: delta at DATA_W+1 bits, so it can never wrap
    // ------------------------------------------------------------------
    logic               v2_reg;
    logic signed [DATA_W:0] d2_reg;
    logic [SHIFT_W-1:0] sh2_reg;
    logic [DATA_W-1:0]  bias2_reg;
    logic               z2_reg;
    logic [DATA_W:0]    d_next;

    assign d_next = {x1_reg[DATA_W-1], x1_reg} - {bp1_reg[DATA_W-1], bp1_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            d2_reg    <= '0;
            sh2_reg   <= '0;
            bias2_reg <= '0;
            z2_reg    <= 1'b0;
        end else if (en) begin
            v2_reg    <= v1_reg;
            d2_reg    <= d_next;
            sh2_reg   <= sh1_reg;
            bias2_reg <= bias1_reg;
            z2_reg    <= z1_reg;
        end
    end

    // ------------------------------------------------------------------
    // S3: shift, add bias at DATA_W+2 bits, clamp
    // ------------------------------------------------------------------
    logic signed [DATA_W:0] d_shift;
    logic [DATA_W+1:0]      r_sum;
    logic                   ovf;
    logic [DATA_W-1:0]      y_next;
    logic                   sat_next;

    assign d_shift = d2_reg >>> sh2_reg;
    assign r_sum   = {d_shift[DATA_W], d_shift} + {{2{bias2_reg[DATA_W-1]}}, bias2_reg};
    // In range exactly when the top three bits agree.
    assign ovf     = ~((r_sum[DATA_W+1] == r_sum[DATA_W]) && (r_sum[DATA_W] == r_sum[DATA_W-1]));

    always_comb begin
        y_next   = r_sum[DATA_W-1:0];
        sat_next = 1'b0;
        if (z2_reg) begin
            y_next   = '0;
            sat_next = 1'b0;
        end else if (ovf) begin
            y_next   = r_sum[DATA_W+1] ? Y_MIN : Y_MAX;
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= v2_reg;
            if (v2_reg) begin
                out_y   <= y_next;
                out_sat <= sat_next;
            end
        end
    end

endmodule
